// File: rtl/fwrisc_regfile_dbg_pkg.sv
// Shared encodings for the register-file debug port: command opcodes,
// controller states and the default acknowledge/error response bytes.
package fwrisc_regfile_dbg_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_DUMP  = 2'd2,
    OP_RSVD  = 2'd3
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_SEND    = 3'd3,
    ST_WR      = 3'd4,
    ST_ACK     = 3'd5
  } dbg_state_e;

  localparam logic [7:0] DBG_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DBG_ERR_BYTE = 8'hEE;

  // Little-endian byte lane selection: lane 0 is bits 7:0.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fwrisc_dbg_byte_ser.sv
// Byte serializer: sends either one byte or a 32-bit word (LSB first) on a
// valid/ready stream, holding each byte until the sink takes it.
module fwrisc_dbg_byte_ser
  import fwrisc_regfile_dbg_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_single,
  input  logic [31:0] i_word,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        o_done
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_single;
  logic        w_last;

  assign w_last = r_single || (r_cnt == 2'd3);
  assign o_done = tx_valid && tx_ready && w_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word   <= '0;
      r_cnt    <= '0;
      r_single <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (i_load) begin
      r_word   <= i_word;
      r_cnt    <= 2'd0;
      r_single <= i_single;
      tx_valid <= 1'b1;
      tx_data  <= i_word[7:0];
    end else if (tx_valid && tx_ready) begin
      if (w_last) begin
        tx_valid <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + 2'd1;
        tx_data <= word_byte(r_word, r_cnt + 2'd1);
      end
    end
  end

endmodule

// File: rtl/fwrisc_regfile_dbg.sv
// Debug access controller for the core register file: single reads/writes
// and a full dump, streamed back as bytes while the core is halted.
module fwrisc_regfile_dbg
  import fwrisc_regfile_dbg_pkg::*;
#(
  parameter int         NUM_REGS = 64,
  parameter logic [7:0] ACK_BYTE = DBG_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE = DBG_ERR_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_halted,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wen,
  output logic        busy
);

  localparam logic [6:0] REG_LIMIT = 7'(NUM_REGS);
  localparam logic [6:0] LAST_IDX  = 7'(NUM_REGS - 1);

  dbg_state_e  r_state;
  logic        r_dump;
  logic [6:0]  r_idx;

  dbg_op_e     w_op;
  logic        w_accept;
  logic        w_in_range;
  logic        w_is_err;
  logic [5:0]  w_next_raddr;
  logic        w_ser_load;
  logic        w_ser_single;
  logic [31:0] w_ser_word;
  logic        w_ser_done;

  assign w_op         = dbg_op_e'(cmd_op);
  assign cmd_ready    = (r_state == ST_IDLE) && core_halted;
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_in_range   = {1'b0, cmd_addr} < REG_LIMIT;
  assign w_is_err     = (w_op == OP_RSVD) ||
                        (((w_op == OP_READ) || (w_op == OP_WRITE)) && !w_in_range);
  assign w_next_raddr = r_idx[5:0] + 6'd1;

  // Error bytes are loaded straight from IDLE so they never touch the file.
  always_comb begin
    w_ser_load   = 1'b0;
    w_ser_single = 1'b0;
    w_ser_word   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_err) begin
          w_ser_load   = 1'b1;
          w_ser_single = 1'b1;
          w_ser_word   = {24'b0, ERR_BYTE};
        end
      end
      ST_RD_CAP: begin
        w_ser_load = 1'b1;
        w_ser_word = rf_rdata;
      end
      ST_WR: begin
        w_ser_load   = 1'b1;
        w_ser_single = 1'b1;
        w_ser_word   = {24'b0, ACK_BYTE};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dump   <= 1'b0;
      r_idx    <= '0;
      rf_raddr <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_wen   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_err) begin
              r_state <= ST_ACK;
            end else begin
              case (w_op)
                OP_READ: begin
                  r_dump   <= 1'b0;
                  rf_raddr <= cmd_addr;
                  r_state  <= ST_RD_ADDR;
                end
                OP_WRITE: begin
                  // x0 is hardwired, so the write is acknowledged but dropped.
                  if (cmd_addr != 6'd0) begin
                    rf_wen   <= 1'b1;
                    rf_waddr <= cmd_addr;
                    rf_wdata <= cmd_wdata;
                  end
                  r_state <= ST_WR;
                end
                default: begin
                  r_dump   <= 1'b1;
                  r_idx    <= '0;
                  rf_raddr <= '0;
                  r_state  <= ST_RD_ADDR;
                end
              endcase
            end
          end
        end
        ST_RD_ADDR: r_state <= ST_RD_CAP;
        ST_RD_CAP:  r_state <= ST_SEND;
        ST_SEND: begin
          // A dump stops at the last register or once the core resumes.
          if (w_ser_done) begin
            if (r_dump && core_halted && (r_idx != LAST_IDX)) begin
              r_idx    <= r_idx + 7'd1;
              rf_raddr <= w_next_raddr;
              r_state  <= ST_RD_ADDR;
            end else begin
              r_dump  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WR: begin
          rf_wen  <= 1'b0;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          if (w_ser_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fwrisc_dbg_byte_ser u_ser (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_ser_load),
    .i_single (w_ser_single),
    .i_word   (w_ser_word),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .o_done   (w_ser_done)
  );

endmodule

// File: tb/tb_fwrisc_regfile_dbg.sv
// Scoreboard bench for the register-file debug port: a byte-stream reference
// model feeds expectation queues that a negedge monitor drains.
module tb_fwrisc_regfile_dbg;
  import fwrisc_regfile_dbg_pkg::*;

  localparam int NREGS = 32;

  logic        clock;
  logic        reset;
  logic        core_halted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic [5:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        busy;

  fwrisc_regfile_dbg #(.NUM_REGS(NREGS)) dut (
    .clock       (clock),
    .reset       (reset),
    .core_halted (core_halted),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wen      (rf_wen),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file stand-in: registered read, x0 reads as zero.
  logic [31:0] rfMem [64];
  always @(posedge clock) begin
    rf_rdata <= (rf_raddr == 6'd0) ? 32'd0 : rfMem[rf_raddr];
    if (rf_wen) rfMem[rf_waddr] <= rf_wdata;
  end

  logic [31:0] refRegs [NREGS];
  logic [7:0]  expQ [$];
  logic [37:0] wrQ [$];
  int assertCount = 0;
  int errCount    = 0;
  int byteCount   = 0;
  int readyMode   = 0;
  int pulses      = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    errCount++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Sink: tx_ready pattern selectable by the stimulus thread.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 3) != 0);
        2: tx_ready = 1'b0;
        default: begin
          if (pulses > 0) begin
            tx_ready = 1'b1;
            pulses--;
          end else begin
            tx_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: byte scoreboard, stall stability and write-port checks.
  initial begin
    bit         prevStall;
    logic [7:0] prevData;
    logic [7:0] expByte;
    logic [37:0] expWr;
    prevStall = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
          checkOutput("tx_hold_data", {24'b0, tx_data}, {24'b0, prevData});
        end
        if (tx_valid && tx_ready) begin
          if (expQ.size() == 0) begin
            assertCount++;
            errCount++;
            $display("[TB] FAIL tx_unexpected_byte: got %h, expected no byte", tx_data);
          end else begin
            expByte = expQ.pop_front();
            checkOutput("tx_byte", {24'b0, tx_data}, {24'b0, expByte});
          end
          byteCount++;
        end
        if (rf_wen) begin
          if (wrQ.size() == 0) begin
            assertCount++;
            errCount++;
            $display("[TB] FAIL rf_wen_unexpected: got addr %0d data %h, expected no write", rf_waddr, rf_wdata);
          end else begin
            expWr = wrQ.pop_front();
            checkOutput("rf_write", {26'b0, rf_waddr} ^ 32'(rf_wdata == expWr[31:0] ? 0 : 32'hFFFF0000),
                        {26'b0, expWr[37:32]});
          end
        end
        prevStall = tx_valid && !tx_ready;
        prevData  = tx_data;
      end
    end
  end

  // Reference model: pushes expected bytes/writes, then drives the handshake.
  task automatic applyStimulus(input int op, input int addr, input logic [31:0] data,
                               input int dumpLimit, input bit dropHalt);
    logic [31:0] w;
    int expLat;
    int t;
    int lat;
    if (op == 3 || ((op == 0 || op == 1) && addr >= NREGS)) begin
      expQ.push_back(8'hEE);
      expLat = 0;
    end else if (op == 1) begin
      if (addr != 0) begin
        wrQ.push_back({addr[5:0], data});
        refRegs[addr] = data;
      end
      expQ.push_back(8'hA5);
      expLat = 1;
    end else begin
      for (int r = 0; r < ((op == 0) ? 1 : dumpLimit); r++) begin
        w = refRegs[(op == 0) ? addr : r];
        for (int b = 0; b < 4; b++) expQ.push_back(8'((w >> (8 * b)) & 32'hFF));
      end
      expLat = 2;
    end
    @(posedge clock);
    #1;
    cmd_op    = op[1:0];
    cmd_addr  = addr[5:0];
    cmd_wdata = data;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!cmd_ready) begin
      reportTimeout("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    if (dropHalt) core_halted = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput("first_byte_latency", lat, expLat);
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while ((busy || tx_valid) && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (busy || tx_valid) reportTimeout("idle_wait");
    @(negedge clock);
    #1;
    checkOutput("resp_queue_drained", expQ.size(), 0);
  endtask

  initial begin
    logic [5:0] savedRaddr;
    int base;
    int t;
    core_halted = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    reset       = 1'b1;
    for (int i = 0; i < NREGS; i++) refRegs[i] = 32'd0;
    #2 reset = 1'b0;
    #2;
    checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'b0, tx_data}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    checkOutput("rst_rf_raddr", {26'b0, rf_raddr}, 32'd0);
    checkOutput("rst_rf_waddr", {26'b0, rf_waddr}, 32'd0);
    checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] preload registers with their own index");
    readyMode = 0;
    for (int i = 1; i < NREGS; i++) begin
      applyStimulus(1, i, 32'(i), 0, 1'b0);
      waitIdle();
    end

    $display("[TB] full dump with sink stalls");
    readyMode = 1;
    applyStimulus(2, 0, 32'd0, NREGS, 1'b0);
    waitIdle();
    checkOutput("dump_end_raddr", {26'b0, rf_raddr}, NREGS - 1);

    $display("[TB] directed reads and writes");
    readyMode = 0;
    applyStimulus(1, 5, 32'h12345678, 0, 1'b0);
    waitIdle();
    applyStimulus(0, 5, 32'd0, 0, 1'b0);
    waitIdle();
    applyStimulus(1, 3, 32'hCAFEF00D, 0, 1'b0);
    waitIdle();
    applyStimulus(1, 0, 32'hDEADBEEF, 0, 1'b0);
    waitIdle();
    applyStimulus(0, 0, 32'd0, 0, 1'b0);
    waitIdle();
    applyStimulus(0, 31, 32'd0, 0, 1'b0);
    waitIdle();
    savedRaddr = rf_raddr;
    applyStimulus(0, 40, 32'd0, 0, 1'b0);
    waitIdle();
    checkOutput("err_read_raddr_kept", {26'b0, rf_raddr}, {26'b0, savedRaddr});
    applyStimulus(0, 32, 32'd0, 0, 1'b0);
    waitIdle();
    applyStimulus(1, 45, 32'h0BADF00D, 0, 1'b0);
    waitIdle();
    applyStimulus(3, 7, 32'd0, 0, 1'b0);
    waitIdle();

    $display("[TB] core resumes during single commands");
    applyStimulus(0, 3, 32'd0, 0, 1'b1);
    waitIdle();
    core_halted = 1'b1;
    applyStimulus(1, 9, 32'h5A5A1234, 0, 1'b1);
    waitIdle();
    core_halted = 1'b1;

    $display("[TB] core resumes during dump");
    readyMode = 0;
    base = byteCount;
    applyStimulus(2, 0, 32'd0, 3, 1'b0);
    t = 0;
    while (byteCount < base + 9 && t < 500) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (byteCount < base + 9) reportTimeout("dump_progress");
    core_halted = 1'b0;
    waitIdle();
    checkOutput("dump_stop_raddr", {26'b0, rf_raddr}, 32'd2);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 6'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checkOutput("no_accept_while_running", {31'b0, cmd_ready}, 32'd0);
      checkOutput("idle_while_running", {31'b0, busy}, 32'd0);
    end
    cmd_valid   = 1'b0;
    core_halted = 1'b1;
    #1;
    checkOutput("ready_after_halt", {31'b0, cmd_ready}, 32'd1);

    $display("[TB] reset during third byte");
    readyMode = 3;
    pulses    = 0;
    base      = byteCount;
    applyStimulus(0, 7, 32'd0, 0, 1'b0);
    pulses = 2;
    t = 0;
    while (byteCount < base + 2 && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (byteCount < base + 2) reportTimeout("reset_test_progress");
    checkOutput("byte2_pending", {31'b0, tx_valid}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_tx_data", {24'b0, tx_data}, 32'd0);
    expQ.delete();
    readyMode = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("no_resume_after_reset", {31'b0, tx_valid}, 32'd0);
    applyStimulus(0, 7, 32'd0, 0, 1'b0);
    waitIdle();

    $display("[TB] randomized commands");
    readyMode = 1;
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 2 && $urandom_range(0, 2) != 0) op = 0;
      applyStimulus(op, $urandom_range(0, 63), $urandom, NREGS, 1'b0);
      waitIdle();
    end

    checkOutput("final_tx_queue_empty", expQ.size(), 0);
    checkOutput("final_wr_queue_empty", wrQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
    $finish;
  end

endmodule

// File: doc/fwrisc_regfile_dbg.md
FWRISC_REGFILE_DBG -- requirements
Module: fwrisc_regfile_dbg

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64, number of implemented registers dumped/addressable (1..64).
REQ-002 SHALL have parameter ACK_BYTE, default 8'hA5, byte returned after a write.
REQ-003 SHALL have parameter ERR_BYTE, default 8'hEE, byte returned for an out-of-range address.
REQ-004 clock  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 core_halted  input  1  core stopped; register file port free for debug use.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  command accepted on cycle with cmd_valid&&cmd_ready.
REQ-009 cmd_op  input  2  0=READ, 1=WRITE, 2=DUMP, 3=reserved.
REQ-010 cmd_addr  input  6  register index for READ/WRITE.
REQ-011 cmd_wdata  input  32  WRITE data.
REQ-012 tx_valid  output  1  response byte present.
REQ-013 tx_ready  input  1  sink accepts byte.
REQ-014 tx_data  output  8  response byte.
REQ-015 rf_raddr  output  6  register file read address; file registers it, data valid next cycle.
REQ-016 rf_rdata  input  32  register file read data.
REQ-017 rf_waddr / rf_wdata / rf_wen  output  6/32/1  register file write port.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 States SHALL be IDLE, RD_ADDR, RD_CAP, SEND, WR, ACK.
REQ-020 cmd_ready SHALL equal (state==IDLE)&&core_halted; no command accepted while core_halted=0.
REQ-021 READ accept, cmd_addr<NUM_REGS: IDLE->RD_ADDR (rf_raddr=addr)->RD_CAP (capture rf_rdata)->SEND; first tx_valid 2 cycles after accept.
REQ-022 SEND SHALL emit 4 bytes little-endian (bits 7:0 first); each byte advances only on tx_valid&&tx_ready.
REQ-023 tx_data SHALL stay stable while tx_valid&&!tx_ready; tx_valid never drops before acceptance except on reset.
REQ-024 WRITE accept, cmd_addr<NUM_REGS: WR asserts rf_wen for exactly one cycle with captured addr/data, then ACK emits ACK_BYTE.
REQ-025 WRITE to address 0 SHALL not assert rf_wen but SHALL still emit ACK_BYTE.
REQ-026 READ/WRITE with cmd_addr>=NUM_REGS SHALL make no register file access and emit one ERR_BYTE.
REQ-027 DUMP SHALL read addresses 0..NUM_REGS-1 in order, 4 bytes each via RD_ADDR/RD_CAP/SEND; index never wraps; after last byte of NUM_REGS-1 -> IDLE.
REQ-028 If core_halted falls during DUMP, current register's 4 bytes SHALL complete, then IDLE; no further rf reads.
REQ-029 If core_halted falls during single READ/WRITE, that command SHALL complete normally.
REQ-030 cmd_op=3 SHALL be accepted and emit one ERR_BYTE.
REQ-031 rf_raddr SHALL hold its value from RD_ADDR through RD_CAP.
REQ-032 Byte counter 2 bits, register index 7 bits (terminal compare at NUM_REGS-1 without overflow).

Reset
REQ-033 On reset low: state=IDLE, tx_valid=0, tx_data=0, rf_wen=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, busy=0, counters=0, immediately (asynchronous).
REQ-034 Reset mid-SEND SHALL drop tx_valid without completing the byte; after release first byte needs a new command.

Structure
REQ-035 Package fwrisc_regfile_dbg_pkg SHALL hold op encoding enum, state enum, ACK/ERR byte defaults.
REQ-036 One sub-module fwrisc_dbg_byte_ser SHALL serialize a 32-bit word or single byte onto tx_* with handshake; FSM in top.

Verification
REQ-037 READ addr 5 with rf reg5=32'h12345678, tx_ready=1 -> bytes 78,56,34,12; first tx_valid 2 cycles after accept.
REQ-038 WRITE addr 3 data 32'hCAFEF00D -> single-cycle rf_wen, rf_waddr=3, rf_wdata=CAFEF00D; then byte A5.
REQ-039 WRITE addr 0 -> rf_wen never asserted; byte A5; READ addr 40 with NUM_REGS=32 -> byte EE, no rf_raddr change.
REQ-040 DUMP with NUM_REGS=4, regs={0,1,2,3}, random tx_ready stalls -> 16 bytes 00 00 00 00 01 00 00 00 ... 03 00 00 00, data stable during stalls, then IDLE.
REQ-041 DUMP, drop core_halted during reg 2 byte 1 -> reg 2 bytes complete, no reg 3 read, cmd_ready stays 0 until core_halted=1.
REQ-042 Assert reset during SEND byte 2 -> tx_valid=0 same cycle, busy=0; fresh READ afterwards returns correct 4 bytes.
